upsample2x_unpool: RTL

- Nearest-neighbour 2x upsampler: the inverse-direction companion to the max-pool stage.
- Reads NUM_MAPS pooled feature maps of IN_H x IN_W 8-bit pixels from the source RAM.
- Writes each map to the destination RAM as 2*IN_H x 2*IN_W: every input pixel is replicated into a 2x2 block.
- Uses the same start/end pulse handshake and the same single-port RAM read/write port style as the pooling stages.

---
 rtl/upsample2x_unpool.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/upsample2x_unpool.sv
// Nearest-neighbour 2x upsampler: reads pooled maps row by row into a row buffer
// and writes every row twice with each pixel duplicated, giving a 2x2 replication.
module upsample2x_unpool #(
  parameter int IN_W     = 12,
  parameter int IN_H     = 12,
  parameter int NUM_MAPS = 4,
  parameter int RD_LAT   = 2,
  parameter int RD_BASE  = 0,
  parameter int WR_BASE  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_UP,
  output logic        end_UP,
  output logic        busy,
  output logic [15:0] ram_addr_r,
  output logic        ram_en_r,
  input  logic [7:0]  ram_data_r,
  output logic [15:0] ram_addr_w,
  output logic [7:0]  ram_data_w,
  output logic        ram_en,
  output logic        ram_wea
);

  localparam int          CW       = $clog2(IN_W);
  localparam logic [7:0]  LAST_RD  = 8'(IN_W - 1);
  localparam logic [7:0]  LAST_WR  = 8'(2 * IN_W - 1);
  localparam logic [7:0]  LAST_ROW = 8'(IN_H - 1);
  localparam logic [15:0] LAST_MAP = 16'(NUM_MAPS - 1);
  localparam logic [1:0]  LAST_DRN = 2'(RD_LAT - 1);
  localparam logic [15:0] RD_B     = 16'(RD_BASE);
  localparam logic [15:0] WR_B     = 16'(WR_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_WR_A, S_WR_B, S_DONE
  } state_t;

  state_t          r_state;
  logic [7:0]      r_col;
  logic [1:0]      r_drn;
  logic [7:0]      r_row;
  logic [15:0]     r_map;
  logic [7:0]      r_rowbuf [IN_W];
  logic [RD_LAT-1:0] r_vld_p;
  logic [CW-1:0]   r_idx_p [RD_LAT];

  logic [7:0]      w_nxt;
  logic [CW-1:0]   w_nidx;

  // Buffer column feeding the next write cycle (output column j maps to j>>1).
  assign w_nxt  = r_col + 8'd1;
  assign w_nidx = CW'(w_nxt >> 1);

  // Capture pipeline: request column travels RD_LAT stages alongside its valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p <= '0;
      for (int i = 0; i < RD_LAT; i++) r_idx_p[i] <= '0;
      for (int i = 0; i < IN_W; i++) r_rowbuf[i] <= '0;
    end else begin
      r_vld_p[0] <= ram_en_r;
      r_idx_p[0] <= r_col[CW-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_idx_p[i] <= r_idx_p[i-1];
      end
      if (r_vld_p[RD_LAT-1]) r_rowbuf[r_idx_p[RD_LAT-1]] <= ram_data_r;
    end
  end

  // Control FSM; every RAM-side output is set up on the edge entering its cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_drn      <= '0;
      r_row      <= '0;
      r_map      <= '0;
      ram_addr_r <= RD_B;
      ram_en_r   <= 1'b0;
      ram_addr_w <= WR_B;
      ram_data_w <= '0;
      ram_en     <= 1'b0;
      ram_wea    <= 1'b0;
      end_UP     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ram_en_r   <= 1'b0;
          ram_en     <= 1'b0;
          ram_wea    <= 1'b0;
          end_UP     <= 1'b0;
          ram_addr_r <= RD_B;
          ram_addr_w <= WR_B;
          r_row      <= '0;
          r_map      <= '0;
          r_col      <= '0;
          if (start_UP) begin
            r_state  <= S_READ;
            ram_en_r <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_READ: begin
          ram_addr_r <= ram_addr_r + 16'd1;
          if (r_col == LAST_RD) begin
            r_state  <= S_DRAIN;
            ram_en_r <= 1'b0;
            r_drn    <= '0;
          end else begin
            r_col <= r_col + 8'd1;
          end
        end
        S_DRAIN: begin
          if (r_drn == LAST_DRN) begin
            r_state    <= S_WR_A;
            r_col      <= '0;
            ram_en     <= 1'b1;
            ram_wea    <= 1'b1;
            ram_data_w <= r_rowbuf[0];
          end else begin
            r_drn <= r_drn + 2'd1;
          end
        end
        S_WR_A, S_WR_B: begin
          if (r_col != LAST_WR) begin
            r_col      <= w_nxt;
            ram_data_w <= r_rowbuf[w_nidx];
            ram_addr_w <= ram_addr_w + 16'd1;
          end else if (r_state == S_WR_A) begin
            r_state    <= S_WR_B;
            r_col      <= '0;
            ram_data_w <= r_rowbuf[0];
            ram_addr_w <= ram_addr_w + 16'd1;
          end else begin
            ram_en     <= 1'b0;
            ram_wea    <= 1'b0;
            ram_data_w <= '0;
            r_col      <= '0;
            if (r_row != LAST_ROW) begin
              r_row      <= r_row + 8'd1;
              r_state    <= S_READ;
              ram_en_r   <= 1'b1;
              ram_addr_w <= ram_addr_w + 16'd1;
            end else if (r_map != LAST_MAP) begin
              r_row      <= '0;
              r_map      <= r_map + 16'd1;
              r_state    <= S_READ;
              ram_en_r   <= 1'b1;
              ram_addr_w <= ram_addr_w + 16'd1;
            end else begin
              // Final write keeps its address so ram_addr_w ends on the last location.
              r_state <= S_DONE;
              end_UP  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          end_UP  <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
